sdram_ctrl: RTL and testbench
=============================

Name: sdram_ctrl

Overview:
Sequencing controller for the 16-bit SDR SDRAM. It replaces the fixed block-RAM command list with a live FSM: power-up init, periodic auto-refresh, and single 32-bit word read/write as a burst of 2 x 16 bits. Policy is closed-page with auto-precharge. It sits between one requester (TTA memory port) and the SDRAM IOBs; the DQ tristate buffers stay in the top level.

Parameters:
INIT_CYCLES, 4096, power-up wait before first PRECHARGE; CKE rises at INIT_CYCLES/2
REFRESH_CYCLES, 640, clocks between refresh requests (7.8 us at 83 MHz)
TRP, 2, precharge-to-command clocks
TRFC, 8, refresh-to-command clocks
TRCD, 2, ACTIVE-to-READ/WRITE clocks
TWR, 2, last write data to precharge start clocks
RD_LAT, 3, clocks from READ on pins to first data word registered (CL=2 + input register)

Ports:
clk  in  1  controller and SDRAM clock
rst  in  1  asynchronous, active-high reset
req  in  1  access request; held with addr/wr/wdata until ack
wr  in  1  1 = write, 0 = read
addr  in  23  word address {bank[22:21], row[20:8], col[7:0]}; column pins = {col,1'b0}
wdata  in  32  write word; low half first
ack  out  1  one-cycle pulse: request accepted, inputs sampled
rvalid  out  1  one-cycle pulse: rdata valid
rdata  out  32  read word {second half, first half}
ready  out  1  init complete
sdr_cke  out  1  clock enable
sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n  out  1 each  command
sdr_ba  out  2  bank
sdr_a  out  13  address
sdr_dm  out  2  data mask (always 0 after reset)
dq_o  out  16  write data to OBUFT
dq_oe  out  1  drive enable to OBUFT
dq_i  in  16  data from IBUF

Behaviour:
- Reset values: sdr_cke=0, command=NOP with cs_n=1 (all command pins 1), ba=0, a=0, dm=0, dq_o=0, dq_oe=0, ack=0, rvalid=0, rdata=0, ready=0. Reset mid-operation aborts and restarts INIT_WAIT.
- All SDRAM outputs registered; a command decided in state S appears on pins the next clock. Between commands: NOP (cs_n=0, ras/cas/we=1).
- States: INIT_WAIT -> INIT_PRE -> INIT_REF1 -> INIT_REF2 -> INIT_LMR -> IDLE; IDLE -> REFRESH | ACTIVATE; ACTIVATE -> WRITE | READ; WRITE/READ/REFRESH -> IDLE after timer. One down-counter serves all waits.
- INIT_WAIT: count INIT_CYCLES; CKE=1 from INIT_CYCLES/2, held 1 thereafter.
- INIT_PRE: PRECHARGE all (a[10]=1), wait TRP. INIT_REF1/2: AUTO REFRESH, each wait TRFC.
- INIT_LMR: LOAD MODE, a=13'h0021 (BL=2, sequential, CL=2), ba=0; wait 2; then ready=1 and IDLE.
- Refresh timer free-runs from ready=1; at terminal count sets refresh_pend. Any access completes well inside REFRESH_CYCLES, so no overflow.
- IDLE arbitration: refresh_pend has priority over req. REFRESH issues AUTO REFRESH, clears refresh_pend, waits TRFC.
- On accepting req in IDLE: ack=1 for one clock, addr/wr/wdata latched. ACTIVATE issues ACTIVE (ba, row), waits TRCD.
- WRITE: WRITE with a[10]=1 (auto-precharge), col; dq_oe=1 with dq_o=wdata[15:0] on that pin cycle, wdata[31:16] next cycle, then dq_oe=0. Wait 1+TWR+TRP before IDLE.
- READ: READ with a[10]=1; dq_i registered every clock; first half at RD_LAT, second at RD_LAT+1 after READ on pins; rvalid pulses with rdata = {second, first} the clock after the second half. Return to IDLE once rvalid issued; TRP met by then.
- Back-to-back requests: ack for next request no earlier than IDLE re-entry; req held high is served repeatedly, one ack each.
- req before ready is ignored, no ack.

Test Plan:
- Reset, INIT_CYCLES=64 -> CKE rises at clk 32; PRECHARGE a[10]=1, 2 refreshes TRFC apart, LMR a=0021, ready=1; no ack for early req.
- Write addr=0, wdata=3333_a37d then read addr=0 against SDRAM model -> single ack each; pins show a37d then 3333; rvalid with rdata=3333_a37d.
- Writes 9999_8888 @col0, 3333_a37d @col1, read both -> rdata 9999_8888 then 3333_a37d; distinct bank/row in addr -> correct ba/row on ACTIVE.
- REFRESH_CYCLES=100, req held constantly -> refresh issued within one access of each terminal count, before the pending req.
- Assert rst mid-WRITE -> pins immediately NOP/cs_n=1, dq_oe=0, cke=0, ready=0; full init repeats.
- Model checks: tRCD, tRP, tRFC, tWR never violated over 1000 random read/write ops; read data matches scoreboard.

Source files
------------

// File: rtl/sdram_ctrl_if.sv
// Requester-side bus of the SDRAM sequencer: one 32-bit word per request,
// held by the master until ack.
interface sdram_ctrl_if;
   logic        req;
   logic        wr;
   logic [22:0] addr;
   logic [31:0] wdata;
   logic        ack;
   logic        rvalid;
   logic [31:0] rdata;
   logic        ready;

   modport master (output req, wr, addr, wdata, input ack, rvalid, rdata, ready);
   modport slave  (input req, wr, addr, wdata, output ack, rvalid, rdata, ready);
endinterface

// File: rtl/sdram_ctrl.sv
// Live command sequencer for a 16-bit SDR SDRAM: power-up init, periodic
// auto-refresh and closed-page single-word (2 x 16) read/write.
//
// state      | meaning
// -----------+--------------------------------------------------------
// INIT_WAIT  | power-up wait, pins deselected, CKE raised half way
// INIT_PRE   | PRECHARGE all issued, waiting tRP
// INIT_REF1  | first AUTO REFRESH issued, waiting tRFC
// INIT_REF2  | second AUTO REFRESH issued, waiting tRFC
// INIT_LMR   | LOAD MODE issued (BL=2, sequential, CL=2), waiting tMRD
// IDLE       | ready; refresh has priority over a request
// REFRESH    | AUTO REFRESH issued, waiting tRFC
// ACTIVATE   | ACTIVE issued, waiting tRCD
// WRITE      | WRITE+AP issued, second beat then tWR + tRP
// READ       | READ+AP issued, collecting both halves
module sdram_ctrl #(
   parameter int INIT_CYCLES    = 4096,
   parameter int REFRESH_CYCLES = 640,
   parameter int TRP            = 2,
   parameter int TRFC           = 8,
   parameter int TRCD           = 2,
   parameter int TWR            = 2,
   parameter int RD_LAT         = 3
) (
   input  logic        clk,
   input  logic        rst,
   sdram_ctrl_if.slave bus,
   output logic        sdr_cke,
   output logic        sdr_cs_n,
   output logic        sdr_ras_n,
   output logic        sdr_cas_n,
   output logic        sdr_we_n,
   output logic [1:0]  sdr_ba,
   output logic [12:0] sdr_a,
   output logic [1:0]  sdr_dm,
   output logic [15:0] dq_o,
   output logic        dq_oe,
   input  logic [15:0] dq_i
);

   localparam int TW = 16;
   localparam logic [TW-1:0] CKE_AT = TW'(INIT_CYCLES / 2);

   // {cs_n, ras_n, cas_n, we_n}
   localparam logic [3:0] CMD_DESEL = 4'b1111;
   localparam logic [3:0] CMD_NOP   = 4'b0111;
   localparam logic [3:0] CMD_ACT   = 4'b0011;
   localparam logic [3:0] CMD_READ  = 4'b0101;
   localparam logic [3:0] CMD_WRITE = 4'b0100;
   localparam logic [3:0] CMD_PRE   = 4'b0010;
   localparam logic [3:0] CMD_REF   = 4'b0001;
   localparam logic [3:0] CMD_LMR   = 4'b0000;

   typedef enum logic [3:0] {
      S_INIT_WAIT, S_INIT_PRE, S_INIT_REF1, S_INIT_REF2, S_INIT_LMR,
      S_IDLE, S_REFRESH, S_ACTIVATE, S_WRITE, S_READ
   } state_t;

   state_t          state, state_nxt;
   logic [TW-1:0]   timer, timer_nxt;
   logic            timer_zero;
   logic [3:0]      cmd_nxt;
   logic [1:0]      ba_nxt;
   logic [12:0]     a_nxt;
   logic [15:0]     dq_o_nxt;
   logic            dq_oe_nxt;
   logic            accept, go_refresh, init_done, rd_first, rd_last;

   logic [1:0]      bank_q;
   logic [7:0]      col_q;
   logic            wr_q;
   logic [31:0]     wdata_q;
   logic [15:0]     dq_q;
   logic [15:0]     half_q;
   logic [TW-1:0]   ref_cnt;
   logic            ref_pend;
   logic [12:0]     col_a;

   assign timer_zero = (timer == '0);
   // Auto-precharge on a[10]; the 16-bit column is the word column shifted left.
   assign col_a      = {2'b00, 1'b1, 1'b0, col_q, 1'b0};

   always_comb begin
      state_nxt  = state;
      timer_nxt  = timer_zero ? timer : timer - 1'b1;
      cmd_nxt    = CMD_NOP;
      ba_nxt     = sdr_ba;
      a_nxt      = sdr_a;
      dq_o_nxt   = '0;
      dq_oe_nxt  = 1'b0;
      accept     = 1'b0;
      go_refresh = 1'b0;
      init_done  = 1'b0;
      rd_first   = 1'b0;
      rd_last    = 1'b0;
      case (state)
         S_INIT_WAIT: begin
            cmd_nxt = CMD_DESEL;
            if (timer_zero) begin
               state_nxt = S_INIT_PRE;
               timer_nxt = TW'(TRP - 1);
               cmd_nxt   = CMD_PRE;
               ba_nxt    = 2'b00;
               a_nxt     = 13'h0400;
            end
         end
         S_INIT_PRE: begin
            if (timer_zero) begin
               state_nxt = S_INIT_REF1;
               timer_nxt = TW'(TRFC - 1);
               cmd_nxt   = CMD_REF;
            end
         end
         S_INIT_REF1: begin
            if (timer_zero) begin
               state_nxt = S_INIT_REF2;
               timer_nxt = TW'(TRFC - 1);
               cmd_nxt   = CMD_REF;
            end
         end
         S_INIT_REF2: begin
            if (timer_zero) begin
               state_nxt = S_INIT_LMR;
               timer_nxt = TW'(1);
               cmd_nxt   = CMD_LMR;
               ba_nxt    = 2'b00;
               a_nxt     = 13'h0021;
            end
         end
         S_INIT_LMR: begin
            if (timer_zero) begin
               state_nxt = S_IDLE;
               init_done = 1'b1;
            end
         end
         S_IDLE: begin
            if (ref_pend) begin
               state_nxt  = S_REFRESH;
               timer_nxt  = TW'(TRFC - 1);
               cmd_nxt    = CMD_REF;
               go_refresh = 1'b1;
            end else if (bus.req) begin
               state_nxt = S_ACTIVATE;
               timer_nxt = TW'(TRCD - 1);
               cmd_nxt   = CMD_ACT;
               ba_nxt    = bus.addr[22:21];
               a_nxt     = bus.addr[20:8];
               accept    = 1'b1;
            end
         end
         S_REFRESH: begin
            if (timer_zero) state_nxt = S_IDLE;
         end
         S_ACTIVATE: begin
            if (timer_zero) begin
               ba_nxt = bank_q;
               a_nxt  = col_a;
               if (wr_q) begin
                  state_nxt = S_WRITE;
                  timer_nxt = TW'(TWR + TRP);
                  cmd_nxt   = CMD_WRITE;
                  dq_oe_nxt = 1'b1;
                  dq_o_nxt  = wdata_q[15:0];
               end else begin
                  state_nxt = S_READ;
                  timer_nxt = TW'(RD_LAT + 1);
                  cmd_nxt   = CMD_READ;
               end
            end
         end
         S_WRITE: begin
            // Second beat follows the WRITE command cycle directly.
            if (timer == TW'(TWR + TRP)) begin
               dq_oe_nxt = 1'b1;
               dq_o_nxt  = wdata_q[31:16];
            end
            if (timer_zero) state_nxt = S_IDLE;
         end
         S_READ: begin
            rd_first = (timer == TW'(1));
            rd_last  = timer_zero;
            if (timer_zero) state_nxt = S_IDLE;
         end
         default: state_nxt = S_INIT_WAIT;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_INIT_WAIT;
         timer      <= TW'(INIT_CYCLES - 1);
         sdr_cke    <= 1'b0;
         {sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n} <= CMD_DESEL;
         sdr_ba     <= '0;
         sdr_a      <= '0;
         sdr_dm     <= '0;
         dq_o       <= '0;
         dq_oe      <= 1'b0;
         bus.ack    <= 1'b0;
         bus.rvalid <= 1'b0;
         bus.rdata  <= '0;
         bus.ready  <= 1'b0;
         bank_q     <= '0;
         col_q      <= '0;
         wr_q       <= 1'b0;
         wdata_q    <= '0;
         dq_q       <= '0;
         half_q     <= '0;
         ref_cnt    <= TW'(REFRESH_CYCLES - 1);
         ref_pend   <= 1'b0;
      end else begin
         state   <= state_nxt;
         timer   <= timer_nxt;
         {sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n} <= cmd_nxt;
         sdr_ba  <= ba_nxt;
         sdr_a   <= a_nxt;
         sdr_dm  <= '0;
         dq_o    <= dq_o_nxt;
         dq_oe   <= dq_oe_nxt;
         if (state == S_INIT_WAIT && timer == CKE_AT) sdr_cke <= 1'b1;

         bus.ack <= accept;
         if (accept) begin
            bank_q  <= bus.addr[22:21];
            col_q   <= bus.addr[7:0];
            wr_q    <= bus.wr;
            wdata_q <= bus.wdata;
         end

         dq_q       <= dq_i;
         bus.rvalid <= rd_last;
         if (rd_first) half_q <= dq_q;
         if (rd_last)  bus.rdata <= {dq_q, half_q};
         if (init_done) bus.ready <= 1'b1;

         // Refresh interval timer runs only once init is complete.
         if (go_refresh) ref_pend <= 1'b0;
         if (!bus.ready) begin
            ref_cnt <= TW'(REFRESH_CYCLES - 1);
         end else if (ref_cnt == '0) begin
            ref_cnt  <= TW'(REFRESH_CYCLES - 1);
            ref_pend <= 1'b1;
         end else begin
            ref_cnt <= ref_cnt - 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_sdram_ctrl.sv
// Directed and random bench for sdram_ctrl with a behavioural SDRAM model
// that also watches command spacing on the pins.
module tb_sdram_ctrl;
   localparam int INIT_CYCLES    = 64;
   localparam int REFRESH_CYCLES = 100;
   localparam int TRP  = 2;
   localparam int TRFC = 8;
   localparam int TRCD = 2;
   localparam int TWR  = 2;
   localparam int K_PRE  = INIT_CYCLES;
   localparam int K_REF1 = K_PRE + TRP;
   localparam int K_REF2 = K_REF1 + TRFC;
   localparam int K_LMR  = K_REF2 + TRFC;
   localparam int K_RDY  = K_LMR + 2;

   localparam logic [3:0] C_DESEL = 4'b1111;
   localparam logic [3:0] C_NOP   = 4'b0111;
   localparam logic [3:0] C_ACT   = 4'b0011;
   localparam logic [3:0] C_RD    = 4'b0101;
   localparam logic [3:0] C_WR    = 4'b0100;
   localparam logic [3:0] C_PRE   = 4'b0010;
   localparam logic [3:0] C_REF   = 4'b0001;
   localparam logic [3:0] C_LMR   = 4'b0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        sdr_cke, sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n;
   logic [1:0]  sdr_ba;
   logic [12:0] sdr_a;
   logic [1:0]  sdr_dm;
   logic [15:0] dq_o;
   logic        dq_oe;
   logic [15:0] dq_i = '0;
   logic [3:0]  cmd;

   always #5 clk = ~clk;

   sdram_ctrl_if bus ();

   sdram_ctrl #(.INIT_CYCLES(INIT_CYCLES), .REFRESH_CYCLES(REFRESH_CYCLES)) dut (
      .clk(clk), .rst(rst), .bus(bus),
      .sdr_cke(sdr_cke), .sdr_cs_n(sdr_cs_n), .sdr_ras_n(sdr_ras_n),
      .sdr_cas_n(sdr_cas_n), .sdr_we_n(sdr_we_n), .sdr_ba(sdr_ba), .sdr_a(sdr_a),
      .sdr_dm(sdr_dm), .dq_o(dq_o), .dq_oe(dq_oe), .dq_i(dq_i)
   );

   assign cmd = {sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n};

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_range(input string tag, input int val, input int lo, input int hi);
      n_tests++;
      assert (val >= lo && val <= hi) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d..%0d", tag, val, lo, hi);
      end
   endtask

   // SDRAM model and timing monitor
   logic [31:0] mem [logic [22:0]];
   logic [31:0] sb  [logic [22:0]];
   logic [12:0] row_of [4];
   int          cyc = 0;
   int          last_ref = -1000, last_pre = -1000, last_wr = -1000;
   int          last_rd = -1000, last_act = -1000;
   int          wr_phase = 0;
   logic [22:0] wr_key;
   logic [15:0] wr_lo;
   int          rd_age = 99;
   logic [31:0] rd_word;
   int          ack_total = 0, ref_total = 0, rv_total = 0;
   bit          held_mode = 1'b0;
   int          prev_ref_held = -1;

   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         last_ref = -1000; last_pre = -1000; last_wr = -1000;
         last_rd = -1000; last_act = -1000;
         wr_phase = 0;
         rd_age = 99;
         dq_i = '0;
      end else begin
         if (bus.ack) ack_total++;
         if (bus.rvalid) rv_total++;
         if (wr_phase == 1) begin
            check("dq_oe beat2", dq_oe, 1);
            mem[wr_key] = {dq_o, wr_lo};
            wr_phase = 2;
         end else if (wr_phase == 2) begin
            check("dq_oe release", dq_oe, 0);
            wr_phase = 0;
         end
         rd_age++;
         if (rd_age == 2)      dq_i = rd_word[15:0];
         else if (rd_age == 3) dq_i = rd_word[31:16];
         else                  dq_i = 16'($urandom);
         if (!sdr_cs_n && cmd != C_NOP) begin
            check("cke at command", sdr_cke, 1);
            check_range("tRFC", cyc - last_ref, TRFC, 1 << 30);
            check_range("tRP", cyc - last_pre, TRP, 1 << 30);
            check_range("tWR+tRP", cyc - last_wr, 1 + TWR + TRP, 1 << 30);
            check_range("read tRP", cyc - last_rd, 2 + TRP, 1 << 30);
            case (cmd)
               C_REF: begin
                  last_ref = cyc;
                  ref_total++;
                  if (held_mode) begin
                     if (prev_ref_held >= 0)
                        check_range("refresh gap", cyc - prev_ref_held,
                                    REFRESH_CYCLES - 15, REFRESH_CYCLES + 15);
                     prev_ref_held = cyc;
                  end
               end
               C_PRE: last_pre = cyc;
               C_ACT: begin
                  last_act = cyc;
                  row_of[sdr_ba] = sdr_a;
               end
               C_WR: begin
                  check_range("tRCD write", cyc - last_act, TRCD, 1 << 30);
                  check("dq_oe beat1", dq_oe, 1);
                  check("write a10", sdr_a[10], 1);
                  wr_key   = {sdr_ba, row_of[sdr_ba], sdr_a[8:1]};
                  wr_lo    = dq_o;
                  wr_phase = 1;
                  last_wr  = cyc;
               end
               C_RD: begin
                  check_range("tRCD read", cyc - last_act, TRCD, 1 << 30);
                  check("read a10", sdr_a[10], 1);
                  wr_key  = {sdr_ba, row_of[sdr_ba], sdr_a[8:1]};
                  rd_word = mem.exists(wr_key) ? mem[wr_key] : 32'h0;
                  rd_age  = 0;
                  last_rd = cyc;
               end
               default: ;
            endcase
         end
      end
   end

   // Entered right after rst is released on a falling edge; k counts rising edges.
   task automatic init_seq();
      logic [3:0] exp_cmd;
      bus.req  = 1'b1;
      bus.wr   = 1'b0;
      bus.addr = '0;
      for (int k = 1; k <= K_RDY + 6; k++) begin
         @(negedge clk);
         if (k == K_RDY - 4) bus.req = 1'b0;
         exp_cmd = (k < K_PRE) ? C_DESEL : (k == K_PRE) ? C_PRE :
                   (k == K_REF1 || k == K_REF2) ? C_REF : (k == K_LMR) ? C_LMR : C_NOP;
         check($sformatf("init cmd k=%0d", k), cmd, exp_cmd);
         check($sformatf("init cke k=%0d", k), sdr_cke, (k >= INIT_CYCLES / 2));
         check($sformatf("init ready k=%0d", k), bus.ready, (k >= K_RDY));
         check("no ack before ready", bus.ack, 0);
         if (k == K_PRE) check("precharge all a10", sdr_a[10], 1);
         if (k == K_LMR) begin
            check("lmr a", sdr_a, 13'h0021);
            check("lmr ba", sdr_ba, 0);
         end
      end
   endtask

   task automatic access(input bit w, input logic [22:0] ad, input logic [31:0] wd, input bit pins);
      int          n;
      int          acks0;
      logic [31:0] exp;
      acks0     = ack_total;
      bus.req   = 1'b1;
      bus.wr    = w;
      bus.addr  = ad;
      bus.wdata = wd;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.ack && n < 100);
      check("ack seen", bus.ack, 1);
      bus.req = 1'b0;
      if (!bus.ack) return;
      check("active cmd", cmd, C_ACT);
      check("active ba", sdr_ba, ad[22:21]);
      check("active row", sdr_a, ad[20:8]);
      @(negedge clk);
      check("ack pulse", bus.ack, 0);
      if (w) begin
         sb[ad] = wd;
         if (pins) begin
            n = 0;
            while (cmd != C_WR && n < 20) begin
               @(negedge clk);
               n++;
            end
            check("write cmd", cmd, C_WR);
            check("write a", sdr_a, {2'b00, 1'b1, 1'b0, ad[7:0], 1'b0});
            check("write ba", sdr_ba, ad[22:21]);
            check("dq first half", dq_o, wd[15:0]);
            @(negedge clk);
            check("dq second half", dq_o, wd[31:16]);
         end
         repeat (6) @(negedge clk);
      end else begin
         exp = sb.exists(ad) ? sb[ad] : 32'h0;
         n = 0;
         while (!bus.rvalid && n < 30) begin
            @(negedge clk);
            n++;
         end
         check("rvalid seen", bus.rvalid, 1);
         check("rdata", bus.rdata, exp);
         @(negedge clk);
         check("rvalid pulse", bus.rvalid, 0);
      end
      check("one ack per access", ack_total - acks0, 1);
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int refs0, acks0, rv0;
      logic [22:0] ad;
      bus.req = 1'b0; bus.wr = 1'b0; bus.addr = '0; bus.wdata = '0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("rst cke", sdr_cke, 0);
      check("rst cmd", cmd, C_DESEL);
      check("rst ba", sdr_ba, 0);
      check("rst a", sdr_a, 0);
      check("rst dm", sdr_dm, 0);
      check("rst dq_o", dq_o, 0);
      check("rst dq_oe", dq_oe, 0);
      check("rst ack", bus.ack, 0);
      check("rst rvalid", bus.rvalid, 0);
      check("rst rdata", bus.rdata, 0);
      check("rst ready", bus.ready, 0);
      rst = 1'b0;
      init_seq();

      access(1'b1, 23'h0, 32'h3333_a37d, 1'b1);
      access(1'b0, 23'h0, 32'h0, 1'b1);
      access(1'b1, {2'd2, 13'h1a5c, 8'd0}, 32'h9999_8888, 1'b1);
      access(1'b1, {2'd2, 13'h1a5c, 8'd1}, 32'h3333_a37d, 1'b1);
      access(1'b1, {2'd3, 13'h0f0f, 8'hfe}, 32'h0123_4567, 1'b1);
      access(1'b0, {2'd2, 13'h1a5c, 8'd0}, 32'h0, 1'b0);
      access(1'b0, {2'd2, 13'h1a5c, 8'd1}, 32'h0, 1'b0);
      access(1'b0, {2'd3, 13'h0f0f, 8'hfe}, 32'h0, 1'b0);
      check("sb col0 value", sb[{2'd2, 13'h1a5c, 8'd0}], 32'h9999_8888);

      // Request held high: reads served repeatedly while refresh keeps its slot.
      refs0 = ref_total; acks0 = ack_total; rv0 = rv_total;
      held_mode = 1'b1; prev_ref_held = -1;
      bus.req = 1'b1; bus.wr = 1'b0; bus.addr = {2'd2, 13'h1a5c, 8'd0};
      for (int i = 0; i < 350; i++) begin
         @(negedge clk);
         if (bus.rvalid) check("held rdata", bus.rdata, 32'h9999_8888);
      end
      bus.req = 1'b0;
      repeat (20) @(negedge clk);
      held_mode = 1'b0;
      check_range("held refreshes", ref_total - refs0, 3, 4);
      check_range("held acks", ack_total - acks0, 20, 50);
      check("held ack/rvalid balance", ack_total - acks0, rv_total - rv0);

      // Reset in the middle of a write.
      bus.req = 1'b1; bus.wr = 1'b1; bus.addr = {2'd1, 13'h1fff, 8'h40}; bus.wdata = 32'hdead_beef;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.ack && n < 100);
      check("abort ack seen", bus.ack, 1);
      bus.req = 1'b0;
      n = 0;
      while (cmd != C_WR && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("abort write cmd", cmd, C_WR);
      rst = 1'b1;
      #1;
      check("abort cmd", cmd, C_DESEL);
      check("abort dq_oe", dq_oe, 0);
      check("abort cke", sdr_cke, 0);
      check("abort ready", bus.ready, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      init_seq();
      access(1'b0, 23'h0, 32'h0, 1'b0);

      for (int i = 0; i < 1000; i++) begin
         ad = {2'($urandom_range(0, 3)), 13'($urandom_range(0, 3)), 8'($urandom_range(0, 7))};
         access(1'($urandom_range(0, 1)), ad, $urandom, 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
